// File: rtl/lfsr_arbiter_pkg.sv
// Shared types and constants for the LFSR arbiter and its shift-register core.
package lfsr_arbiter_pkg;

  localparam int unsigned N_REQ  = 2;
  localparam int unsigned LFSR_W = 8;

  // Feedback taps s[7]^s[5]^s[4]^s[3]
  localparam logic [LFSR_W-1:0] TAPS = 8'b1011_1000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DELIVER = 2'd2
  } state_t;

  // Round-robin winner index: a lone requester wins, on contention the one that did not win last time
  function automatic logic rr_pick(input logic [N_REQ-1:0] r, input logic last);
    logic win;
    win = ~last;
    if (r == 2'b01) begin
      win = 1'b0;
    end else if (r == 2'b10) begin
      win = 1'b1;
    end
    return win;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR: shifts left, feedback enters at bit 0; load has priority over step.
module lfsr_core
  import lfsr_arbiter_pkg::*;
#(
  parameter int unsigned       WIDTH     = LFSR_W,
  parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(1),
  parameter logic [WIDTH-1:0]  TAP_MASK  = WIDTH'(TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next_c
);

  logic fb;

  // Next value after one step, exposed so the owner can capture the final byte on the last step
  always_comb begin
    fb       = ^(q & TAP_MASK);
    q_next_c = {q[WIDTH-2:0], fb};
  end

  // Shift register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= q_next_c;
    end
  end

endmodule

// File: rtl/lfsr_arbiter.sv
// Shares one LFSR between two requesters; each grant delivers WIDTH freshly shifted bits.
module lfsr_arbiter
  import lfsr_arbiter_pkg::*;
#(
  parameter int unsigned      WIDTH        = LFSR_W,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(8'h01)
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed_data,
  output logic             seed_ready,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             rvalid,
  output logic [WIDTH-1:0] rdata,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             rvalid_q, rvalid_d;
  logic             busy_q, busy_d;
  logic             seed_ready_q, seed_ready_d;

  logic             lfsr_en;
  logic             lfsr_load;
  logic [WIDTH-1:0] lfsr_load_val;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_next;

  lfsr_core #(
    .WIDTH     (WIDTH),
    .RESET_VAL (SEED_DEFAULT),
    .TAP_MASK  (WIDTH'(TAPS))
  ) u_core (
    .clk      (CLK),
    .rst_n    (ASYNCRESETN),
    .en       (lfsr_en),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .q        (lfsr_q),
    .q_next_c (lfsr_next)
  );

  // An all-zero seed would lock the LFSR, so it is swapped for the default
  always_comb begin
    lfsr_load_val = (seed_data == '0) ? SEED_DEFAULT : seed_data;
  end

  // Next-state, arbitration and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    rdata_d   = rdata_q;
    gnt_d     = '0;
    rvalid_d  = 1'b0;
    lfsr_en   = 1'b0;
    lfsr_load = 1'b0;

    case (state_q)
      IDLE: begin
        if (seed_valid) begin
          lfsr_load = 1'b1;
        end else if (req != '0) begin
          owner_d = rr_pick(req, last_q);
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        lfsr_en = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Outputs are registered, so the byte and grant are set up on the last step
          state_d  = DELIVER;
          rdata_d  = lfsr_next;
          gnt_d    = N_REQ'(1) << owner_q;
          rvalid_d = 1'b1;
        end
      end
      DELIVER: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d       = (state_d != IDLE);
    seed_ready_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      rdata_q      <= '0;
      gnt_q        <= '0;
      rvalid_q     <= 1'b0;
      busy_q       <= 1'b0;
      seed_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      rdata_q      <= rdata_d;
      gnt_q        <= gnt_d;
      rvalid_q     <= rvalid_d;
      busy_q       <= busy_d;
      seed_ready_q <= seed_ready_d;
    end
  end

  assign gnt        = gnt_q;
  assign rvalid     = rvalid_q;
  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign seed_ready = seed_ready_q;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Directed bench for lfsr_arbiter with a grant/byte scoreboard.
module tb_lfsr_arbiter;

  logic       CLK;
  logic       ASYNCRESETN;
  logic       seed_valid;
  logic [7:0] seed_data;
  logic       seed_ready;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       rvalid;
  logic [7:0] rdata;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic [1:0] g;
    logic [7:0] d;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] m_s;
  logic       m_last;
  int         cyc;

  lfsr_arbiter u_dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .seed_valid  (seed_valid),
    .seed_data   (seed_data),
    .seed_ready  (seed_ready),
    .req         (req),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .busy        (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] step8(input logic [7:0] s);
    logic [7:0] v;
    v = s;
    for (int i = 0; i < 8; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  // Predict the next transaction for request pattern r and queue it
  task automatic push_exp(input logic [1:0] r);
    logic w;
    if (r == 2'b01) w = 1'b0;
    else if (r == 2'b10) w = 1'b1;
    else w = ~m_last;
    m_last = w;
    m_s = step8(m_s);
    sb.push_back({(w ? 2'b10 : 2'b01), m_s});
  endtask

  // Count cycles until a delivery is seen; returns at the negedge of the delivery cycle
  task automatic wait_grant(output int n);
    n = 0;
    do begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
    end while (!rvalid && n < 40);
    chk("grant_seen", rvalid, 1'b1);
  endtask

  task automatic load_seed(input logic [7:0] d);
    logic acc;
    int   n;
    @(posedge CLK);
    #1;
    seed_valid = 1'b1;
    seed_data  = d;
    n = 0;
    do begin
      @(negedge CLK);
      acc = seed_ready;
      @(posedge CLK);
      n++;
    end while (!acc && n < 40);
    #1;
    seed_valid = 1'b0;
    chk("seed_accepted", acc, 1'b1);
    m_s = (d == 8'h00) ? 8'h01 : d;
  endtask

  // Scoreboard consumer and grant/valid consistency monitor
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("rvalid_vs_gnt", rvalid, (gnt != 2'b00));
      if (rvalid) begin
        chk("grant_expected", (sb.size() > 0), 1'b1);
        chk("rdata_nonzero", (rdata != 8'h00), 1'b1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_gnt", gnt, e.g);
          chk("sb_rdata", rdata, e.d);
        end
      end
    end
  end

  initial begin
    ASYNCRESETN = 1'b0;
    req         = 2'b00;
    seed_valid  = 1'b0;
    seed_data   = 8'h00;
    m_s         = 8'h01;
    m_last      = 1'b1;

    // Reset values
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_seed_ready", seed_ready, 1'b1);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    mon_en      = 1'b1;

    // Single requester held: first byte latency and back-to-back spacing
    @(posedge CLK);
    #1;
    push_exp(2'b01);
    push_exp(2'b01);
    req = 2'b01;
    wait_grant(cyc);
    chk("lat_first", cyc, 9);
    chk("first_byte", rdata, 8'h1C);
    chk("first_gnt", gnt, 2'b01);
    wait_grant(cyc);
    req = 2'b00;
    chk("lat_b2b", cyc, 10);

    // Seed 0xFF then requester 1
    load_seed(8'hFF);
    push_exp(2'b10);
    req = 2'b10;
    wait_grant(cyc);
    req = 2'b00;
    chk("ff_byte", rdata, 8'h0B);
    chk("ff_gnt", gnt, 2'b10);

    // Zero seed replaced by default; full period of 255 grants
    load_seed(8'h00);
    chk("zero_seed_q", u_dut.u_core.q, 8'h01);
    for (int i = 0; i < 255; i++) push_exp(2'b01);
    req = 2'b01;
    for (int i = 0; i < 255; i++) begin
      wait_grant(cyc);
      if (i == 0) chk("zero_seed_byte", rdata, 8'h1C);
      if (i == 254) req = 2'b00;
    end
    chk("period_wrap", rdata, 8'h01);

    // Contention alternates starting with requester 0 after reset
    @(negedge CLK);
    ASYNCRESETN = 1'b0;
    m_s    = 8'h01;
    m_last = 1'b1;
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) push_exp(2'b11);
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_grant(cyc);
      chk("alt_gnt", gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i == 3) req = 2'b00;
    end

    // Seed raised mid-SHIFT waits for IDLE
    @(posedge CLK);
    #1;
    push_exp(2'b11);
    req = 2'b11;
    repeat (5) @(posedge CLK);
    #1;
    seed_valid = 1'b1;
    seed_data  = 8'hA5;
    @(negedge CLK);
    chk("midshift_seed_ready", seed_ready, 1'b0);
    chk("midshift_busy", busy, 1'b1);
    wait_grant(cyc);
    req = 2'b00;
    chk("deliver_seed_ready", seed_ready, 1'b0);
    @(negedge CLK);
    chk("idle_seed_ready", seed_ready, 1'b1);
    @(posedge CLK);
    #1;
    seed_valid = 1'b0;
    m_s = 8'hA5;
    chk("deferred_seed_q", u_dut.u_core.q, 8'hA5);

    // Seed and request in the same IDLE cycle: seed first, grant starts next cycle
    @(posedge CLK);
    #1;
    seed_valid = 1'b1;
    seed_data  = 8'h5A;
    req        = 2'b01;
    m_s        = 8'h5A;
    push_exp(2'b01);
    @(posedge CLK);
    #1;
    seed_valid = 1'b0;
    @(negedge CLK);
    chk("seedreq_busy", busy, 1'b0);
    chk("seedreq_seed_ready", seed_ready, 1'b1);
    chk("seedreq_q", u_dut.u_core.q, 8'h5A);
    wait_grant(cyc);
    req = 2'b00;
    chk("seedreq_lat", cyc, 9);

    // Asynchronous reset in the middle of SHIFT
    @(posedge CLK);
    #1;
    req = 2'b01;
    repeat (4) @(posedge CLK);
    #2;
    ASYNCRESETN = 1'b0;
    req = 2'b00;
    #1;
    chk("arst_gnt", gnt, 2'b00);
    chk("arst_rvalid", rvalid, 1'b0);
    chk("arst_rdata", rdata, 8'h00);
    chk("arst_busy", busy, 1'b0);
    chk("arst_seed_ready", seed_ready, 1'b1);
    chk("arst_lfsr", u_dut.u_core.q, 8'h01);
    m_s    = 8'h01;
    m_last = 1'b1;
    repeat (3) @(negedge CLK);
    ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1;
    push_exp(2'b01);
    req = 2'b01;
    wait_grant(cyc);
    req = 2'b00;
    chk("post_arst_byte", rdata, 8'h1C);

    repeat (12) @(posedge CLK);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
